// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width and the receiver FSM state encoding.
package spi_pkg;

    localparam int SPI_WORD_W = 16;

    typedef enum logic [1:0] {
        WAIT_HI,
        IDLE,
        SHIFT,
        ERR
    } rx_state_t;

endpackage

// File: rtl/spi_rx_deser_if.sv
// Valid/ready word bus between the SPI deserialiser (master) and its consumer (slave).
interface spi_rx_deser_if
    import spi_pkg::*;
#(
    parameter int WORD_W = SPI_WORD_W
) ();

    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/spi_rx_sync.sv
// Input synchroniser for one SPI pin: SYNC_STAGES flop chain plus a delayed copy for edges.
module spi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_dly;

    // Reset to 0 so a chip select held low through reset never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_dly   <= 1'b0;
        end else begin
            r_chain[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_dly <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_level = r_chain[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_dly;
    assign o_fall  = ~o_level & r_dly;

endmodule

// File: rtl/spi_rx_deser.sv
// SPI receive deserialiser: MSB-first words on cs_l frames, valid/ready output buffer.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry show-ahead FIFO instead of one holding register.
module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int WORD_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_cs_l,
    input  logic           spi_sclk,
    input  logic           spi_data,
    spi_rx_deser_if.master rx_if,
    output logic           rx_overrun,
    output logic           frame_err,
    output logic           busy
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sclk_rise, w_data_lvl;
    logic w_unused_sclk_lvl, w_unused_sclk_fall, w_unused_data_rise, w_unused_data_fall;

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .i_pin(spi_cs_l),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_pin(spi_sclk),
        .o_level(w_unused_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_unused_sclk_fall)
    );

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst(rst), .i_pin(spi_data),
        .o_level(w_data_lvl), .o_rise(w_unused_data_rise), .o_fall(w_unused_data_fall)
    );

    rx_state_t         r_state, w_state_nx;
    logic [CNT_W-1:0]  r_count, w_count_nx;
    logic [WORD_W-1:0] r_shift, w_shift_nx;
    logic              r_commit, w_commit;
    logic              r_ferr, w_ferr;
    logic              w_full_cnt;

    assign w_full_cnt = (r_count == CNT_W'(WORD_W));

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_shift_nx = r_shift;
        w_commit   = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            WAIT_HI: begin
                if (w_cs_lvl) w_state_nx = IDLE;
            end
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nx = SHIFT;
                    w_count_nx = '0;
                    w_shift_nx = '0;
                end
            end
            SHIFT: begin
                // A cs_l rise shadows any sclk edge seen in the same cycle.
                if (w_cs_rise) begin
                    w_state_nx = IDLE;
                    w_commit   = w_full_cnt;
                    w_ferr     = ~w_full_cnt;
                end else if (w_sclk_rise) begin
                    if (w_full_cnt) begin
                        w_state_nx = ERR;
                    end else begin
                        w_shift_nx = {r_shift[WORD_W-2:0], w_data_lvl};
                        w_count_nx = r_count + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                if (w_cs_rise) begin
                    w_state_nx = IDLE;
                    w_ferr     = 1'b1;
                end
            end
            default: w_state_nx = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= WAIT_HI;
            r_count  <= '0;
            r_commit <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_commit <= w_commit;
            r_ferr   <= w_ferr;
        end
    end

    // The shift register is stable in IDLE, so the buffer reads it a cycle after commit.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nx;
    end

    assign frame_err = r_ferr;
    assign busy      = (r_state == SHIFT) || (r_state == ERR);

    logic              r_ovr;
    logic              r_valid;
    logic [WORD_W-1:0] r_head;
    logic              w_pop;

    assign w_pop = r_valid && rx_if.rx_ready;

`ifdef SPI_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [PTR_W:0]    r_level, w_level_nx;
    logic              w_full, w_push;

    assign w_full     = (r_level == (PTR_W+1)'(FIFO_DEPTH));
    assign w_push     = r_commit && (!w_full || w_pop);
    assign w_level_nx = r_level + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    // Head register mirrors mem[rptr]; an empty or draining FIFO takes the incoming word directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_level <= w_level_nx;
            r_valid <= (w_level_nx != '0);
            r_ovr   <= r_commit && !w_push;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if ((r_level == '0) || (w_pop && (r_level == (PTR_W+1)'(1)))) begin
                if (w_push) r_head <= r_shift;
            end else if (w_pop) begin
                r_head <= r_mem[r_rptr + PTR_W'(1)];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_head  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_commit) begin
                if (!r_valid || rx_if.rx_ready) begin
                    r_head  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

    assign rx_if.rx_data  = r_head;
    assign rx_if.rx_valid = r_valid;
    assign rx_overrun     = r_ovr;

endmodule
